neo_fix_arb: RTL and testbench

Arbiter and address former for the single fix-layer ROM port (S-ROM/SFIX region in SDRAM/BRAM). It shares the port between the video fix-tile fetcher and the ROM loader. It applies the CMC fix bank, or the system-SFIX select, to fetch addresses, and sequences each access through a one-outstanding request/acknowledge handshake. It sits between the fix-layer fetch logic plus the CMC bank output and the memory controller.

---
 rtl/neo_fix_pkg.sv | 20 ++
 rtl/neo_fix_addr_map.sv | 23 ++
 rtl/neo_fix_arb.sv | 153 +++++++++++++++
 tb/tb_neo_fix_arb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/neo_fix_pkg.sv
// Shared types and constants for the fix-layer ROM port arbiter.
// The optional access timeout is enabled by defining NEO_FIX_ARB_TIMEOUT_EN.
package neo_fix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIX_RD = 2'd1,
        ST_LD_WR  = 2'd2
    } fix_state_e;

    localparam int unsigned FIX_AW = 17;
    localparam int unsigned BANK_W = 2;

    // Value of address bit ADDR_W-1 selecting the system SFIX or the cart S-ROM.
    localparam logic SFIX_REGION = 1'b1;
    localparam logic CART_REGION = 1'b0;

    localparam int unsigned TMO_LIMIT = 255;

endpackage

// File: rtl/neo_fix_addr_map.sv
// Combinational fix fetch address former: applies system SFIX select or CMC bank.
module neo_fix_addr_map
    import neo_fix_pkg::*;
#(
    parameter int unsigned ADDR_W = 20
) (
    input  logic              i_fix_sys,
    input  logic              i_cmc_en,
    input  logic [BANK_W-1:0] i_fix_bank,
    input  logic [FIX_AW-1:0] i_fix_addr,
    output logic [ADDR_W-1:0] o_addr
);

    always_comb begin
        o_addr = '0;
        o_addr[FIX_AW-1:0] = i_fix_addr;
        o_addr[ADDR_W-1]   = i_fix_sys ? SFIX_REGION : CART_REGION;
        if (!i_fix_sys && i_cmc_en) begin
            o_addr[FIX_AW +: BANK_W] = i_fix_bank;
        end
    end

endmodule

// File: rtl/neo_fix_arb.sv
// Shares the fix ROM port between fix-tile fetches and the ROM loader.
// Define NEO_FIX_ARB_TIMEOUT_EN to abort accesses lacking mem_ack and expose mem_tmo.
module neo_fix_arb
    import neo_fix_pkg::*;
#(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              fix_req,
    input  logic [16:0]       fix_addr,
    input  logic [1:0]        fix_bank,
    input  logic              fix_sys,
    input  logic              cmc_en,
    output logic [DATA_W-1:0] fix_data,
    output logic              fix_valid,
    output logic              fix_ovf,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_busy,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef NEO_FIX_ARB_TIMEOUT_EN
    ,
    output logic              mem_tmo
`endif
);

    fix_state_e        r_state, w_state_nxt;
    logic              r_fix_pend, r_ld_pend, r_last_fix;
    logic [ADDR_W-1:0] r_fix_addr, r_ld_addr, r_mem_addr;
    logic [DATA_W-1:0] r_ld_data, r_mem_wdata, r_fix_data;
    logic              r_fix_valid, r_fix_ovf;

    logic [ADDR_W-1:0] w_map;
    logic              w_tmo, w_done, w_arb, w_ld_acc;
    logic              w_avail_fix, w_avail_ld, w_grant_fix, w_grant_ld;

    neo_fix_addr_map #(.ADDR_W(ADDR_W)) u_map (
        .i_fix_sys  (fix_sys),
        .i_cmc_en   (cmc_en),
        .i_fix_bank (fix_bank),
        .i_fix_addr (fix_addr),
        .o_addr     (w_map)
    );

`ifdef NEO_FIX_ARB_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_mem_tmo;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_mem_tmo <= 1'b0;
        end else begin
            r_tmo_cnt <= w_arb ? '0 : r_tmo_cnt + 8'd1;
            if (w_tmo) r_mem_tmo <= 1'b1;
        end
    end

    assign w_tmo   = (r_state != ST_IDLE) && !mem_ack && (r_tmo_cnt == 8'(TMO_LIMIT - 1));
    assign mem_tmo = r_mem_tmo;
`else
    assign w_tmo = 1'b0;
`endif

    assign ld_busy  = r_ld_pend || (r_state == ST_LD_WR);
    assign w_ld_acc = ld_wr && !ld_busy;
    assign w_done   = (r_state != ST_IDLE) && (mem_ack || w_tmo);
    // Arbitrate in IDLE and on the completing cycle, so back-to-back grants need no bubble.
    // Same-cycle requests bypass the slots so a fetch reaches the bus one cycle later.
    assign w_arb       = (r_state == ST_IDLE) || w_done;
    assign w_avail_fix = r_fix_pend || fix_req;
    assign w_avail_ld  = r_ld_pend || w_ld_acc;
    assign w_grant_ld  = w_arb && w_avail_ld && (!w_avail_fix || r_last_fix);
    assign w_grant_fix = w_arb && w_avail_fix && !w_grant_ld;

    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        if (w_grant_fix)     w_state_nxt = ST_FIX_RD;
        else if (w_grant_ld) w_state_nxt = ST_LD_WR;
        else if (w_done)     w_state_nxt = ST_IDLE;
        case (r_state)
            ST_FIX_RD: mem_rd = 1'b1;
            ST_LD_WR:  mem_wr = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_fix_pend  <= 1'b0;
            r_fix_addr  <= '0;
            r_ld_pend   <= 1'b0;
            r_ld_addr   <= '0;
            r_ld_data   <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_fix_data  <= '0;
            r_fix_valid <= 1'b0;
            r_fix_ovf   <= 1'b0;
            r_last_fix  <= 1'b0;
        end else begin
            r_fix_valid <= w_done && (r_state == ST_FIX_RD);
            if (w_done && (r_state == ST_FIX_RD)) r_fix_data <= mem_ack ? mem_rdata : '1;
            if (fix_req && r_fix_pend) r_fix_ovf <= 1'b1;

            if (w_grant_fix) begin
                r_fix_pend <= 1'b0;
            end else if (fix_req) begin
                r_fix_pend <= 1'b1;
                r_fix_addr <= w_map;
            end

            if (w_grant_ld) begin
                r_ld_pend <= 1'b0;
            end else if (w_ld_acc) begin
                r_ld_pend <= 1'b1;
                r_ld_addr <= ld_addr;
                r_ld_data <= ld_data;
            end

            if (w_grant_fix) begin
                r_mem_addr <= fix_req ? w_map : r_fix_addr;
                r_last_fix <= 1'b1;
            end else if (w_grant_ld) begin
                r_mem_addr  <= r_ld_pend ? r_ld_addr : ld_addr;
                r_mem_wdata <= r_ld_pend ? r_ld_data : ld_data;
                r_last_fix  <= 1'b0;
            end
        end
    end

    assign fix_data  = r_fix_data;
    assign fix_valid = r_fix_valid;
    assign fix_ovf   = r_fix_ovf;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_neo_fix_arb.sv
// Randomized bench for neo_fix_arb against a transaction-level reference model.
// Define NEO_FIX_ARB_TIMEOUT_EN to also exercise the access timeout.
module tb_neo_fix_arb;

    logic        clk_sys = 1'b0;
    logic        reset, fix_req, fix_sys, cmc_en, ld_wr, mem_ack;
    logic [16:0] fix_addr;
    logic [1:0]  fix_bank;
    logic [19:0] ld_addr;
    logic [15:0] ld_data, mem_rdata;
    logic [15:0] fix_data, mem_wdata;
    logic [19:0] mem_addr;
    logic        fix_valid, fix_ovf, ld_busy, mem_rd, mem_wr;
`ifdef NEO_FIX_ARB_TIMEOUT_EN
    logic        mem_tmo;
`endif

    always #5 clk_sys = ~clk_sys;

    neo_fix_arb #(.ADDR_W(20), .DATA_W(16)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .fix_req   (fix_req),
        .fix_addr  (fix_addr),
        .fix_bank  (fix_bank),
        .fix_sys   (fix_sys),
        .cmc_en    (cmc_en),
        .fix_data  (fix_data),
        .fix_valid (fix_valid),
        .fix_ovf   (fix_ovf),
        .ld_wr     (ld_wr),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_busy   (ld_busy),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef NEO_FIX_ARB_TIMEOUT_EN
        ,
        .mem_tmo   (mem_tmo)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          use_model = 1'b1;

    // Reference model: kind 0 = bus idle, 1 = fix read, 2 = loader write.
    int unsigned m_kind, ack_wait;
    bit          m_fix_pend, m_ld_pend, m_last_fix, m_ovf, m_valid;
    logic [19:0] m_fix_addr, m_ld_addr, m_cur_addr;
    logic [15:0] m_ld_data, m_cur_data, m_fdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [19:0] exp_map(input logic sys, input logic cmc,
                                            input logic [1:0] bank, input logic [16:0] a);
        int unsigned v;
        if (sys)      v = 32'h80000 + a;
        else if (cmc) v = bank * 32'h20000 + a;
        else          v = a;
        return v[19:0];
    endfunction

    task automatic model_step();
        bit done, acc_ld;
        if (reset) begin
            m_kind = 0; m_fix_pend = 0; m_ld_pend = 0; m_last_fix = 0;
            m_ovf = 0; m_valid = 0; m_fix_addr = '0; m_ld_addr = '0;
            m_cur_addr = '0; m_ld_data = '0; m_cur_data = '0; m_fdata = '0;
            return;
        end
        done   = (m_kind != 0) && mem_ack;
        acc_ld = ld_wr && !m_ld_pend && (m_kind != 2);
        if (fix_req && m_fix_pend) m_ovf = 1;
        m_valid = done && (m_kind == 1);
        if (m_valid) m_fdata = mem_rdata;
        if (fix_req) begin
            m_fix_pend = 1;
            m_fix_addr = exp_map(fix_sys, cmc_en, fix_bank, fix_addr);
        end
        if (acc_ld) begin
            m_ld_pend = 1; m_ld_addr = ld_addr; m_ld_data = ld_data;
        end
        if (done) m_kind = 0;
        if (m_kind == 0) begin
            if (m_fix_pend && (!m_ld_pend || !m_last_fix)) begin
                m_kind = 1; m_cur_addr = m_fix_addr; m_fix_pend = 0; m_last_fix = 1;
                ack_wait = $urandom_range(0, 4);
            end else if (m_ld_pend) begin
                m_kind = 2; m_cur_addr = m_ld_addr; m_cur_data = m_ld_data;
                m_ld_pend = 0; m_last_fix = 0;
                ack_wait = $urandom_range(0, 4);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_sys);
        #1;
        if (use_model) begin
            chk("mem_rd",    mem_rd,    m_kind == 1);
            chk("mem_wr",    mem_wr,    m_kind == 2);
            chk("mem_addr",  mem_addr,  m_cur_addr);
            chk("mem_wdata", mem_wdata, m_cur_data);
            chk("fix_valid", fix_valid, m_valid);
            chk("fix_data",  fix_data,  m_fdata);
            chk("ld_busy",   ld_busy,   m_ld_pend || (m_kind == 2));
            chk("fix_ovf",   fix_ovf,   m_ovf);
        end
    endtask

    task automatic clr();
        reset = 0; fix_req = 0; ld_wr = 0; mem_ack = 0;
    endtask

    initial begin
        clr();
        fix_addr = '0; fix_bank = '0; fix_sys = 0; cmc_en = 0;
        ld_addr = '0; ld_data = '0; mem_rdata = '0;
        reset = 1; tick(); tick();
        clr(); tick();
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_ld_busy", ld_busy, 0);

        // Cart CMC read, ack three cycles after the request.
        cmc_en = 1; fix_bank = 2; fix_addr = 17'h00123; fix_req = 1; tick(); clr();
        chk("cart_rd", mem_rd, 1);
        chk("cart_addr", mem_addr, 20'h40123);
        tick(); tick();
        mem_ack = 1; mem_rdata = 16'hBEEF; tick(); clr();
        chk("cart_valid", fix_valid, 1);
        chk("cart_data", fix_data, 16'hBEEF);
        chk("cart_rd_low", mem_rd, 0);
        tick();
        chk("cart_once", fix_valid, 0);

        // System SFIX, then bank ignored without CMC.
        fix_sys = 1; fix_addr = 17'h00010; fix_req = 1; tick(); clr();
        chk("sys_addr", mem_addr, 20'h80010);
        mem_ack = 1; tick(); clr();
        fix_sys = 0; cmc_en = 0; fix_bank = 3; fix_req = 1; tick(); clr();
        chk("nocmc_addr", mem_addr, 20'h00010);
        mem_ack = 1; tick(); clr();

        // Fairness: fix, loader, fix, loader, fix.
        cmc_en = 1; fix_bank = 1; fix_addr = 17'h000AA; fix_req = 1; tick(); clr();
        ld_wr = 1; ld_addr = 20'h12345; ld_data = 16'hA5A5;
        fix_sys = 1; fix_addr = 17'h10000; fix_req = 1; tick(); clr();
        mem_ack = 1; tick(); clr();
        chk("fair_ld", mem_wr, 1);
        chk("fair_ld_addr", mem_addr, 20'h12345);
        mem_ack = 1; ld_wr = 1; ld_addr = 20'h55555; ld_data = 16'h1111; tick(); clr();
        chk("fair_fix", mem_rd, 1);
        chk("fair_fix_addr", mem_addr, 20'h90000);
        chk("ldbusy_fall", ld_busy, 0);
        ld_wr = 1; ld_addr = 20'h0ABCD; ld_data = 16'h5A5A;
        fix_sys = 0; cmc_en = 0; fix_addr = 17'h00777; fix_req = 1; tick(); clr();
        mem_ack = 1; tick(); clr();
        chk("fair_ld2", mem_wr, 1);
        mem_ack = 1; tick(); clr();
        chk("fair_fix2", mem_addr, 20'h00777);
        mem_ack = 1; tick(); clr();

        // Overflow: three requests during one slow access, newest wins.
        fix_addr = 17'h00001; fix_req = 1; tick(); clr();
        for (int i = 1; i <= 3; i++) begin
            fix_addr = 17'(i * 32'h100); fix_req = 1; tick(); clr();
        end
        mem_ack = 1; tick(); clr();
        chk("ovf_flag", fix_ovf, 1);
        chk("ovf_addr", mem_addr, 20'h00300);
        mem_ack = 1; tick(); clr();

        // Reset mid-read, then a stale ack.
        fix_addr = 17'h00042; fix_req = 1; tick(); clr();
        reset = 1; tick(); clr();
        mem_ack = 1; tick(); clr();
        chk("rst_mid_rd", mem_rd, 0);
        chk("rst_mid_valid", fix_valid, 0);
        chk("rst_mid_ovf", fix_ovf, 0);
        chk("rst_mid_addr", mem_addr, 0);
        tick();
        chk("rst_stale_valid", fix_valid, 0);
        chk("rst_stale_rd", mem_rd, 0);

`ifdef NEO_FIX_ARB_TIMEOUT_EN
        begin
            int unsigned k;
            use_model = 0;
            fix_addr = 17'h00005; fix_req = 1; tick(); clr();
            chk("tmo_rd_up", mem_rd, 1);
            k = 0;
            while (mem_rd && k < 300) begin
                tick(); k++;
            end
            chk("tmo_cycles", k, 255);
            chk("tmo_valid", fix_valid, 1);
            chk("tmo_data", fix_data, 16'hFFFF);
            chk("tmo_flag", mem_tmo, 1);
            reset = 1; tick(); clr();
            use_model = 1;
            chk("tmo_rst", mem_tmo, 0);
        end
`endif

        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 399) == 0);
            fix_req   = ($urandom_range(0, 3) == 0);
            fix_addr  = 17'($urandom);
            fix_bank  = 2'($urandom);
            fix_sys   = ($urandom_range(0, 3) == 0);
            cmc_en    = 1'($urandom);
            ld_wr     = ($urandom_range(0, 4) == 0);
            ld_addr   = 20'($urandom);
            ld_data   = 16'($urandom);
            mem_rdata = 16'($urandom);
            if (m_kind != 0) begin
                mem_ack = (ack_wait == 0);
                if (ack_wait > 0) ack_wait--;
            end else begin
                mem_ack = ($urandom_range(0, 7) == 0);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
